mips_regfile_param: RTL
=======================

// Module: mips_regfile_param
// PURPOSE
//   Parametrised register file for the mini MIPS datapath; next generation of the 8x32 register file.
//   Two combinational read ports and one synchronous write port.
//   Optional hardwired-zero register 0 and optional write-to-read bypass.
//   Sequential clear engine zeroes the whole file, one register per cycle, with a busy/done handshake.
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   3   address width; DEPTH = 2**ADDR_W registers
//   ZERO_REG 0   1: register 0 always reads 0 and writes to it are discarded
//   BYPASS   1   1: a read of the register being written this cycle returns write_data
// PORTS
//   clk              in   1       clock; all state updates on rising edge
//   rst              in   1       synchronous, active-high reset
//   signal_reg_write in   1       write enable
//   write_reg        in   ADDR_W  write address
//   write_data       in   DATA_W  write data
//   read_reg_1       in   ADDR_W  read port 1 address
//   read_reg_2       in   ADDR_W  read port 2 address
//   read_data_1      out  DATA_W  read port 1 data (combinational)
//   read_data_2      out  DATA_W  read port 2 data (combinational)
//   clear_req        in   1       request a full-file clear sweep; sampled in IDLE only
//   clear_busy       out  1       high while the sweep is in progress
//   clear_done       out  1       one-cycle pulse after the last register is cleared
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - All DEPTH registers <= 0; FSM <= IDLE; sweep pointer <= 0.
//     - clear_busy=0 and clear_done=0 from the next cycle.
//     - Reset has priority over writes and the sweep; it aborts a sweep mid-operation with no done pulse.
//   Write
//     - At posedge, if signal_reg_write=1 and clear_busy=0: reg[write_reg] <= write_data.
//     - Latency 1 cycle.
//     - If ZERO_REG=1 and write_reg=0, the write is discarded.
//   Read
//     - read_data_n = reg[read_reg_n], 0-cycle combinational.
//     - If ZERO_REG=1 and read_reg_n=0, the port returns 0 (overrides the bypass).
//     - If BYPASS=1, signal_reg_write=1, clear_busy=0 and write_reg==read_reg_n, the port returns write_data in the same cycle.
//     - Both ports may address the same register; both return the same value.
//   Clear FSM, states IDLE / SWEEP / DONE
//     - IDLE:  clear_req=1 -> SWEEP with ptr=0.
//     - SWEEP: each cycle reg[ptr] <= 0 and ptr++; clear_busy=1.
//              After ptr=DEPTH-1 is cleared -> DONE. The sweep lasts exactly DEPTH cycles.
//     - DONE:  clear_done=1 for one cycle, clear_busy=0 -> IDLE.
//     - clear_req in SWEEP or DONE is ignored; it is not queued.
//     - A write presented while clear_busy=1 is dropped, not stalled; the requester must wait for clear_busy=0.
//     - Reads during SWEEP return current array contents (partially cleared); bypass is disabled.
//     - clear_req and signal_reg_write together in IDLE: the write commits, then the sweep starts next cycle and clears it.
//   Widths
//     - ptr is ADDR_W+1 bits wide so the DEPTH-1 terminal value is detected without wrap ambiguity.
// TESTING
//   T1 reset: rst=1 for 2 cycles, read every address -> all reads 0, clear_busy=0, clear_done=0.
//   T2 write/read: write 9 to r0 and 13 to r1 (ZERO_REG=0), then read r0/r1 -> read_data_1=9, read_data_2=13.
//   T3 bypass: write 0xDEADBEEF to r5 with read_reg_1=5 in the same cycle -> read_data_1=0xDEADBEEF before the edge;
//      with BYPASS=0 the port shows the old value until after the edge.
//   T4 zero reg: ZERO_REG=1, write 0x55 to r0 -> read r0 returns 0; bypass is suppressed on r0.
//   T5 sweep: fill r0..r7 with 1..8, pulse clear_req -> clear_busy high for exactly 8 cycles, clear_done pulses once,
//      all reads 0; a write of 7 to r3 during the sweep is dropped.
//   T6 reset mid-sweep: assert rst at sweep cycle 4 -> all registers 0, clear_busy=0 next cycle, no clear_done pulse;
//      a new clear_req after reset completes normally.

Source files
------------

// File: rtl/mips_regfile_param.sv
// Parametrised register file for the mini MIPS datapath.
//
// Two combinational read ports, one synchronous write port, an optional hardwired-zero
// register 0, an optional write-to-read bypass and a sequential clear engine that zeroes
// the whole file one register per cycle.
//
// Ports:
//   clk_i              clock, all state updates on the rising edge
//   rst_i              synchronous active-high reset
//   signal_reg_write_i write enable
//   write_reg_i        write address
//   write_data_i       write data
//   read_reg_1_i       read port 1 address
//   read_reg_2_i       read port 2 address
//   read_data_1_o      read port 1 data (combinational)
//   read_data_2_o      read port 2 data (combinational)
//   clear_req_i        start a full-file clear sweep (honoured only when idle)
//   clear_busy_o       high while the sweep is in progress
//   clear_done_o       one-cycle pulse after the last register is cleared
module mips_regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              signal_reg_write_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [ADDR_W-1:0] read_reg_1_i,
  input  logic [ADDR_W-1:0] read_reg_2_i,
  output logic [DATA_W-1:0] read_data_1_o,
  output logic [DATA_W-1:0] read_data_2_o,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              clear_done_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // Terminal pointer value DEPTH-1; the extra MSB keeps it unambiguous.
  localparam logic [ADDR_W:0] LastPtr = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [Depth];

  logic write_en;
  logic write_keep;

  assign clear_busy_o = (state_q == StSweep);
  assign clear_done_o = (state_q == StDone);

  // Writes are dropped (not stalled) while the sweep owns the array.
  assign write_en   = signal_reg_write_i && !clear_busy_o;
  assign write_keep = write_en && !(ZERO_REG && (write_reg_i == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req_i) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastPtr) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (write_keep) begin
        regs_q[write_reg_i] <= write_data_i;
      end
      if (clear_busy_o) begin
        regs_q[ptr_q[ADDR_W-1:0]] <= '0;
      end
    end
  end

  // Zero-register override has the last word over the bypass.
  always_comb begin
    read_data_1_o = regs_q[read_reg_1_i];
    if (BYPASS && write_en && (write_reg_i == read_reg_1_i)) begin
      read_data_1_o = write_data_i;
    end
    if (ZERO_REG && (read_reg_1_i == '0)) begin
      read_data_1_o = '0;
    end
  end

  always_comb begin
    read_data_2_o = regs_q[read_reg_2_i];
    if (BYPASS && write_en && (write_reg_i == read_reg_2_i)) begin
      read_data_2_o = write_data_i;
    end
    if (ZERO_REG && (read_reg_2_i == '0)) begin
      read_data_2_o = '0;
    end
  end

endmodule
